// File: rtl/k12_alu_if.sv
// Operand/instruction/result bundle between the register-file read side
// and the K12 ALU.
interface k12_alu_if;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] inst;
   logic [7:0]  res;
   logic        cond;

   modport master (output a, b, inst, input res, cond);
   modport slave  (input a, b, inst, output res, cond);
endinterface

// File: rtl/k12_alu.sv
// K12 8-bit ALU: decodes the instruction word, combines operand A with
// operand B or an 8-bit immediate, and registers result plus condition flag.
module k12_alu (
   input  logic        clk,
   input  logic        rst_n,
   k12_alu_if.slave    bus
);

   logic [7:0]  res_q, res_d;
   logic        cond_q, cond_d;

   logic [1:0]  cls;
   logic        imm_sel;
   logic [4:0]  fn;
   logic [7:0]  op2;
   logic [2:0]  sh;
   logic [7:0]  diff;
   logic [15:0] rot_l;
   logic [15:0] rot_r;

   assign cls     = bus.inst[15:14];
   assign imm_sel = bus.inst[13];
   assign fn      = bus.inst[12:8];
   assign op2     = imm_sel ? bus.inst[7:0] : bus.b;
   assign sh      = op2[2:0];
   assign diff    = bus.a - op2;
   // Rotates fall out of shifting a doubled copy of the operand.
   assign rot_l   = {bus.a, bus.a} << sh;
   assign rot_r   = {bus.a, bus.a} >> sh;

   // Next result and flag from the current operands and instruction.
   always_comb begin
      res_d  = 8'h00;
      cond_d = 1'b0;
      if (cls == 2'b00) begin
         case (fn)
            5'h00: res_d = bus.a + op2;
            5'h01: res_d = diff;
            5'h02: res_d = bus.a & op2;
            5'h03: res_d = bus.a | op2;
            5'h04: res_d = bus.a ^ op2;
            5'h05: res_d = ~bus.a;
            5'h06: res_d = 8'h00 - bus.a;
            5'h07: res_d = op2;
            5'h08: res_d = bus.a + 8'd1;
            5'h09: res_d = bus.a - 8'd1;
            5'h0A: res_d = bus.a << sh;
            5'h0B: res_d = bus.a >> sh;
            5'h0C: res_d = $unsigned($signed(bus.a) >>> sh);
            5'h0D: res_d = rot_l[15:8];
            5'h0E: res_d = rot_r[7:0];
            5'h0F: res_d = {bus.a[3:0], bus.a[7:4]};
            5'h10: begin res_d = diff; cond_d = (bus.a == op2); end
            5'h11: begin res_d = diff; cond_d = (bus.a != op2); end
            5'h12: begin res_d = diff; cond_d = (bus.a <  op2); end
            5'h13: begin res_d = diff; cond_d = (bus.a >= op2); end
            5'h14: begin res_d = diff; cond_d = ($signed(bus.a) <  $signed(op2)); end
            5'h15: begin res_d = diff; cond_d = ($signed(bus.a) >= $signed(op2)); end
            5'h16: begin res_d = bus.a; cond_d = bus.a[7]; end
            5'h17: begin res_d = bus.a & op2; cond_d = |(bus.a & op2); end
            default: begin res_d = 8'h00; cond_d = 1'b0; end
         endcase
         // Plain data ops flag a zero result; compares/TST/BIT set their own.
         if (fn < 5'h10) begin
            cond_d = (res_d == 8'h00);
         end
      end
   end

   // Output registers; reset clears them immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= 8'h00;
         cond_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         cond_q <= cond_d;
      end
   end

   assign bus.res  = res_q;
   assign bus.cond = cond_q;

endmodule

// File: tb/tb_k12_alu.sv
// Self-checking bench for k12_alu: directed corner cases, decode, reset,
// exhaustive corner sweep and a random back-to-back stream.
module tb_k12_alu;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   k12_alu_if bus();

   k12_alu u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model from the instruction rules using integer arithmetic.
   function automatic void ref_model(input int a, input int b, input int inst,
                                     output int r, output int c);
      int cls, imm, fn, op2, k, p, sa, so;
      cls = inst / 16384;
      imm = (inst / 8192) % 2;
      fn  = (inst / 256) % 32;
      op2 = imm ? (inst % 256) : b;
      k   = op2 % 8;
      p   = 1 << k;
      sa  = (a >= 128) ? a - 256 : a;
      so  = (op2 >= 128) ? op2 - 256 : op2;
      r = 0;
      c = 0;
      case (fn)
         0:  r = (a + op2) % 256;
         1:  r = (a - op2 + 256) % 256;
         2:  r = a & op2;
         3:  r = a | op2;
         4:  r = a ^ op2;
         5:  r = 255 - a;
         6:  r = (256 - a) % 256;
         7:  r = op2;
         8:  r = (a + 1) % 256;
         9:  r = (a + 255) % 256;
         10: r = (a * p) % 256;
         11: r = a / p;
         12: begin
            if (sa >= 0) r = sa / p;
            else         r = -((-sa + p - 1) / p);
            r = (r + 256) % 256;
         end
         13: r = (a * p) % 256 + a / (256 / p);
         14: r = a / p + (a % p) * (256 / p);
         15: r = (a % 16) * 16 + a / 16;
         16: begin r = (a - op2 + 256) % 256; c = (a == op2); end
         17: begin r = (a - op2 + 256) % 256; c = (a != op2); end
         18: begin r = (a - op2 + 256) % 256; c = (a <  op2); end
         19: begin r = (a - op2 + 256) % 256; c = (a >= op2); end
         20: begin r = (a - op2 + 256) % 256; c = (sa <  so); end
         21: begin r = (a - op2 + 256) % 256; c = (sa >= so); end
         22: begin r = a; c = (a >= 128); end
         23: begin r = a & op2; c = (r != 0); end
         default: begin r = 0; c = 0; end
      endcase
      if (fn < 16) c = (r == 0);
      if (cls != 0) begin
         r = 0;
         c = 0;
      end
   endfunction

   // Drive inputs on the falling edge; the result appears after the next rise.
   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [15:0] inst);
      @(negedge clk);
      bus.a    = a;
      bus.b    = b;
      bus.inst = inst;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      bus.a    = 8'h00;
      bus.b    = 8'h00;
      bus.inst = 16'h0000;
      #2;
      checks++;
      if (bus.res !== 8'h00 || bus.cond !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial res=%h cond=%b expected 00/0", bus.res, bus.cond);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(8'h00, 8'h5A, 16'h0700);
      checks++;
      if (bus.res !== 8'h5A || bus.cond !== 1'b0) begin
         errors++;
         $display("FAIL reset_preload res=%h cond=%b expected 5A/0", bus.res, bus.cond);
      end
      // Assert reset between edges; outputs must clear with no clock edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.res !== 8'h00 || bus.cond !== 1'b0) begin
         errors++;
         $display("FAIL reset_async res=%h cond=%b expected 00/0", bus.res, bus.cond);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.res !== 8'h00 || bus.cond !== 1'b0) begin
         errors++;
         $display("FAIL reset_held res=%h cond=%b expected 00/0", bus.res, bus.cond);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.res !== 8'h5A || bus.cond !== 1'b0) begin
         errors++;
         $display("FAIL reset_release res=%h cond=%b expected 5A/0", bus.res, bus.cond);
      end
   endtask

   task automatic test_directed();
      logic [7:0]  va [14] = '{8'h7F, 8'hFF, 8'h01, 8'h01, 8'h80, 8'h80, 8'h81, 8'h81,
                               8'h81, 8'h81, 8'h81, 8'h81, 8'h3C, 8'hA5};
      logic [7:0]  vb [14] = '{8'h01, 8'h01, 8'h00, 8'h55, 8'h01, 8'h01, 8'h01, 8'h01,
                               8'h01, 8'h00, 8'h00, 8'h00, 8'h77, 8'h12};
      logic [15:0] vi [14] = '{16'h0000, 16'h0000, 16'h20FF, 16'h20FF, 16'h1200, 16'h1400,
                               16'h0D00, 16'h0C00, 16'h0B00, 16'h0B00, 16'h0D00, 16'h0C00,
                               16'h4000, 16'h1800};
      logic [7:0]  vr [14] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h03, 8'hC0,
                               8'h40, 8'h81, 8'h81, 8'h81, 8'h00, 8'h00};
      logic        vc [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 14; i++) begin
         drive(va[i], vb[i], vi[i]);
         checks++;
         if (bus.res !== vr[i] || bus.cond !== vc[i]) begin
            errors++;
            $display("FAIL directed_%0d a=%h b=%h inst=%h res=%h cond=%b expected %h/%b",
                     i, va[i], vb[i], vi[i], bus.res, bus.cond, vr[i], vc[i]);
         end
      end
   endtask

   task automatic test_decode();
      int r, c;
      logic [15:0] inst;
      logic [7:0]  a, b;
      for (int i = 0; i < 24; i++) begin
         a    = 8'($urandom);
         b    = 8'($urandom);
         inst = 16'($urandom);
         if (i < 12) inst[15:14] = 2'(1 + (i % 3));
         else begin
            inst[15:14] = 2'b00;
            inst[12:11] = 2'b11;
         end
         ref_model(int'(a), int'(b), int'(inst), r, c);
         drive(a, b, inst);
         checks++;
         if (bus.res !== 8'h00 || bus.cond !== 1'b0 || r != 0 || c != 0) begin
            errors++;
            $display("FAIL decode inst=%h res=%h cond=%b expected 00/0", inst, bus.res, bus.cond);
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0]  corner [8] = '{8'h00, 8'h01, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
      logic [7:0]  a, b, bport;
      logic [15:0] inst;
      logic [7:0]  exp_r;
      logic        exp_c;
      int r, c;
      for (int ia = 0; ia < 8; ia++)
         for (int ib = 0; ib < 8; ib++)
            for (int f = 0; f < 32; f++)
               for (int m = 0; m < 2; m++) begin
                  a = corner[ia];
                  b = corner[ib];
                  if (m == 1) begin
                     inst  = {2'b00, 1'b1, 5'(f), b};
                     bport = ~b;
                  end else begin
                     inst  = {2'b00, 1'b0, 5'(f), 8'($urandom)};
                     bport = b;
                  end
                  ref_model(int'(a), int'(bport), int'(inst), r, c);
                  exp_r = 8'(r);
                  exp_c = (c != 0);
                  drive(a, bport, inst);
                  checks++;
                  if (bus.res !== exp_r || bus.cond !== exp_c) begin
                     errors++;
                     $display("FAIL sweep a=%h b=%h inst=%h res=%h cond=%b expected %h/%b",
                              a, bport, inst, bus.res, bus.cond, exp_r, exp_c);
                  end
               end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp_r;
      logic        exp_c;
      logic [15:0] inst;
      int r, c;
      bit pending;
      pending = 1'b0;
      for (int i = 0; i <= 400; i++) begin
         @(negedge clk);
         if (pending) begin
            checks++;
            if (bus.res !== exp_r || bus.cond !== exp_c) begin
               errors++;
               $display("FAIL back_to_back_%0d res=%h cond=%b expected %h/%b",
                        i, bus.res, bus.cond, exp_r, exp_c);
            end
         end
         if (i < 400) begin
            inst = 16'($urandom);
            if ($urandom_range(0, 7) != 0) inst[15:14] = 2'b00;
            bus.a    = 8'($urandom);
            bus.b    = 8'($urandom);
            bus.inst = inst;
            ref_model(int'(bus.a), int'(bus.b), int'(inst), r, c);
            exp_r   = 8'(r);
            exp_c   = (c != 0);
            pending = 1'b1;
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_decode();
      test_sweep();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
